// File: rtl/itch_msg_arbiter_pkg.sv
// Shared constants, state encoding and index helper for the ITCH message arbiter.
package itch_pkg;

    localparam int         ITCH_ADD_MSG_BYTES = 15;
    localparam logic [7:0] ITCH_TYPE_ADD      = 8'h41;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FWD   = 2'd1,
        ARB_PAD   = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_e;

    function automatic logic [7:0] rr_next(input logic [7:0] idx, input logic [7:0] num);
        logic [7:0] inc_v;
        inc_v = idx + 8'd1;
        return (inc_v >= num) ? 8'd0 : inc_v;
    endfunction

endpackage

// File: rtl/itch_msg_arbiter_if.sv
// Source-feed and parser-side AXI-Stream bundle of the ITCH message arbiter.
interface itch_msg_arbiter_if #(
    parameter int NUM_SRC = 2,
    parameter int IDW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic [NUM_SRC*8-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]   s_axis_tvalid;
    logic [NUM_SRC-1:0]   s_axis_tlast;
    logic [NUM_SRC-1:0]   s_axis_tready;
    logic [7:0]           m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic [IDW-1:0]       m_axis_tid;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
    );
endinterface

// File: rtl/itch_msg_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo NUM_SRC.
module rr_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     gnt_idx,
    output logic               any_req
);

    // Scan upward from ptr; the first hit freezes the grant index.
    always_comb begin
        logic [IDW:0] cand_v;
        logic         hit_v;
        logic         found_v;
        gnt_idx = '0;
        found_v = 1'b0;
        cand_v  = '0;
        hit_v   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_v  = {1'b0, ptr} + (IDW+1)'(i);
            cand_v  = (cand_v >= (IDW+1)'(NUM_SRC)) ? cand_v - (IDW+1)'(NUM_SRC) : cand_v;
            hit_v   = !found_v && req[cand_v[IDW-1:0]];
            gnt_idx = hit_v ? cand_v[IDW-1:0] : gnt_idx;
            found_v = found_v | hit_v;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/itch_msg_arbiter.sv
// Round-robin per-message scheduler feeding one ITCH parser, framing every message to MSG_BYTES.
// Optional saturating statistics ports are built when ITCH_ARB_STATS_EN is defined.
module itch_msg_arbiter
    import itch_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int MSG_BYTES = ITCH_ADD_MSG_BYTES,
    parameter int IDW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    itch_msg_arbiter_if.slave  axis
`ifdef ITCH_ARB_STATS_EN
    ,
    output logic [31:0]        stat_msg_cnt,
    output logic [15:0]        stat_short_cnt,
    output logic [15:0]        stat_long_cnt
`endif
);

    localparam int             CNT_W    = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_BYTES - 1);

    arb_state_e         state_r, state_nxt_s;
    logic [IDW-1:0]     grant_r, grant_nxt_s;
    logic [IDW-1:0]     ptr_r, ptr_nxt_s, ptr_wrap_s, win_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               any_req_s, at_last_s;
    logic [7:0]         src_data_s;
    logic               src_valid_s, src_last_s;
    logic [7:0]         m_tdata_s;
    logic               m_tvalid_s, m_tlast_s;
    logic [NUM_SRC-1:0] s_tready_s;
    logic               msg_evt_s, short_evt_s, long_evt_s;

    rr_arbiter #(.NUM_SRC(NUM_SRC), .IDW(IDW)) u_rr (
        .req     (axis.s_axis_tvalid),
        .ptr     (ptr_r),
        .gnt_idx (win_s),
        .any_req (any_req_s)
    );

    assign src_data_s  = axis.s_axis_tdata[{grant_r, 3'b000} +: 8];
    assign src_valid_s = axis.s_axis_tvalid[grant_r];
    assign src_last_s  = axis.s_axis_tlast[grant_r];
    assign at_last_s   = (cnt_r == LAST_IDX);
    assign ptr_wrap_s  = IDW'(rr_next(8'(grant_r), 8'(NUM_SRC)));

    // State, grant, round-robin pointer and byte counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
            grant_r <= '0;
            ptr_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            ptr_r   <= ptr_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and output mux; data path is combinational from the granted source.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        ptr_nxt_s   = ptr_r;
        cnt_nxt_s   = cnt_r;
        m_tdata_s   = 8'h00;
        m_tvalid_s  = 1'b0;
        m_tlast_s   = 1'b0;
        s_tready_s  = '0;
        msg_evt_s   = 1'b0;
        short_evt_s = 1'b0;
        long_evt_s  = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (any_req_s) begin
                    grant_nxt_s = win_s;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ARB_FWD;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_FWD: begin
                m_tdata_s           = src_data_s;
                m_tvalid_s          = src_valid_s;
                m_tlast_s           = at_last_s;
                s_tready_s[grant_r] = axis.m_axis_tready;
                if (src_valid_s && axis.m_axis_tready) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                    if (src_last_s && at_last_s) begin
                        state_nxt_s = ARB_IDLE;
                        ptr_nxt_s   = ptr_wrap_s;
                        msg_evt_s   = 1'b1;
                    end else if (src_last_s) begin
                        state_nxt_s = ARB_PAD;
                        short_evt_s = 1'b1;
                    end else if (at_last_s) begin
                        // Parser frame is full; the rest of the source message is swallowed.
                        state_nxt_s = ARB_DRAIN;
                        long_evt_s  = 1'b1;
                        msg_evt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ARB_FWD;
                    end
                end else begin
                    state_nxt_s = ARB_FWD;
                end
            end
            ARB_PAD: begin
                m_tvalid_s = 1'b1;
                m_tlast_s  = at_last_s;
                if (axis.m_axis_tready) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                    if (at_last_s) begin
                        state_nxt_s = ARB_IDLE;
                        ptr_nxt_s   = ptr_wrap_s;
                        msg_evt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ARB_PAD;
                    end
                end else begin
                    state_nxt_s = ARB_PAD;
                end
            end
            ARB_DRAIN: begin
                s_tready_s[grant_r] = 1'b1;
                if (src_valid_s && src_last_s) begin
                    state_nxt_s = ARB_IDLE;
                    ptr_nxt_s   = ptr_wrap_s;
                end else begin
                    state_nxt_s = ARB_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    assign axis.m_axis_tdata  = m_tdata_s;
    assign axis.m_axis_tvalid = m_tvalid_s;
    assign axis.m_axis_tlast  = m_tlast_s;
    assign axis.s_axis_tready = s_tready_s;
    assign axis.m_axis_tid    = grant_r;

`ifdef ITCH_ARB_STATS_EN
    logic [31:0] msg_cnt_r;
    logic [15:0] short_cnt_r, long_cnt_r;

    // Saturating message, short-message and long-message counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt_r   <= 32'd0;
            short_cnt_r <= 16'd0;
            long_cnt_r  <= 16'd0;
        end else begin
            if (msg_evt_s && (msg_cnt_r != 32'hFFFF_FFFF)) msg_cnt_r <= msg_cnt_r + 32'd1;
            if (short_evt_s && (short_cnt_r != 16'hFFFF)) short_cnt_r <= short_cnt_r + 16'd1;
            if (long_evt_s && (long_cnt_r != 16'hFFFF)) long_cnt_r <= long_cnt_r + 16'd1;
        end
    end

    assign stat_msg_cnt   = msg_cnt_r;
    assign stat_short_cnt = short_cnt_r;
    assign stat_long_cnt  = long_cnt_r;
`else
    logic stats_unused_s;
    assign stats_unused_s = ^{msg_evt_s, short_evt_s, long_evt_s};
`endif

endmodule

// File: tb/tb_itch_msg_arbiter.sv
// Directed self-checking bench for itch_msg_arbiter (two sources, 15-byte frames).
module tb_itch_msg_arbiter;
    import itch_pkg::*;

    typedef struct {
        int         cyc;
        logic [7:0] tid;
        logic       last;
        logic [7:0] data;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    logic bp_en;
    logic par_ready;
    int   cyc;
    int   err_cnt;
    int   chk_cnt;
    int   mir_n;
    int   mir_err;
    int   load_cyc;
    logic [8:0] src0_q[$];
    logic [8:0] src1_q[$];
    obs_t       out_q[$];

    itch_msg_arbiter_if #(.NUM_SRC(2), .IDW(1)) bus ();

`ifdef ITCH_ARB_STATS_EN
    logic [31:0] stat_msg_cnt;
    logic [15:0] stat_short_cnt, stat_long_cnt;
`endif

    itch_msg_arbiter #(.NUM_SRC(2), .MSG_BYTES(15), .IDW(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axis  (bus)
`ifdef ITCH_ARB_STATS_EN
        ,
        .stat_msg_cnt   (stat_msg_cnt),
        .stat_short_cnt (stat_short_cnt),
        .stat_long_cnt  (stat_long_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_byte(input int src, input logic [7:0] d, input logic last);
        if (src == 0) src0_q.push_back({last, d});
        else          src1_q.push_back({last, d});
    endtask

    task automatic push_cnt_msg(input int src, input int n, input logic [7:0] base);
        for (int b = 0; b < n; b++) push_byte(src, base + 8'(b), b == n - 1);
    endtask

    task automatic push_add(input int src, input logic [63:0] oid, input logic [15:0] qty, input logic [31:0] px);
        logic [119:0] m;
        m = {8'h41, oid, qty, px};
        for (int b = 0; b < 15; b++) push_byte(src, m[119 - 8*b -: 8], b == 14);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input string tag, input int n);
        int budget;
        budget = 4 * n + 40;
        while (out_q.size() < n && budget > 0) begin
            step();
            budget--;
        end
        chk({tag, "_nbytes"}, 64'(out_q.size()), 64'(n));
    endtask

    // Expected frame: n_src counting bytes from base, zero pad after, tlast only on byte 14.
    task automatic chk_frame(input string tag, input int off, input int tid, input int n_src, input logic [7:0] base);
        logic [7:0] exp_d;
        for (int b = 0; b < 15; b++) begin
            if (off + b < out_q.size()) begin
                exp_d = (b < n_src) ? base + 8'(b) : 8'h00;
                chk($sformatf("%s_data%0d", tag, b), 64'(out_q[off+b].data), 64'(exp_d));
                chk($sformatf("%s_last%0d", tag, b), 64'(out_q[off+b].last), 64'(b == 14));
                chk($sformatf("%s_tid%0d", tag, b), 64'(out_q[off+b].tid), 64'(tid));
            end else begin
                chk($sformatf("%s_missing%0d", tag, b), 64'(out_q.size()), 64'(off + b + 1));
            end
        end
    endtask

    task automatic chk_add(input string tag, input int tid, input logic [63:0] oid, input logic [15:0] qty, input logic [31:0] px);
        logic [119:0] got;
        got = '0;
        for (int b = 0; b < 15 && b < out_q.size(); b++) begin
            got = {got[111:0], out_q[b].data};
            chk($sformatf("%s_last%0d", tag, b), 64'(out_q[b].last), 64'(b == 14));
            chk($sformatf("%s_tid%0d", tag, b), 64'(out_q[b].tid), 64'(tid));
        end
        chk({tag, "_type"}, 64'(got[119:112]), 64'(ITCH_TYPE_ADD));
        chk({tag, "_oid"}, got[111:48], oid);
        chk({tag, "_qty"}, 64'(got[47:32]), 64'(qty));
        chk({tag, "_px"}, 64'(got[31:0]), 64'(px));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
        chk({tag, "_sready"}, 64'(bus.s_axis_tready), 64'd0);
        chk({tag, "_mlast"}, 64'(bus.m_axis_tlast), 64'd0);
        chk({tag, "_mdata"}, 64'(bus.m_axis_tdata), 64'd0);
        chk({tag, "_mtid"}, 64'(bus.m_axis_tid), 64'd0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        src0_q.delete();
        src1_q.delete();
        step();
        out_q.delete();
        rst_n = 1'b1;
        step();
    endtask

    // Source and parser-ready driver, updated on the falling edge.
    initial begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b1;
        par_ready         = 1'b1;
        forever begin
            @(negedge clk);
            bus.s_axis_tvalid[0]   = (src0_q.size() > 0);
            bus.s_axis_tdata[7:0]  = (src0_q.size() > 0) ? src0_q[0][7:0] : 8'h00;
            bus.s_axis_tlast[0]    = (src0_q.size() > 0) ? src0_q[0][8] : 1'b0;
            bus.s_axis_tvalid[1]   = (src1_q.size() > 0);
            bus.s_axis_tdata[15:8] = (src1_q.size() > 0) ? src1_q[0][7:0] : 8'h00;
            bus.s_axis_tlast[1]    = (src1_q.size() > 0) ? src1_q[0][8] : 1'b0;
            par_ready              = bp_en ? ~par_ready : 1'b1;
            bus.m_axis_tready      = par_ready;
        end
    end

    // Handshake monitor on the rising edge: pops sources, records parser-side bytes.
    initial begin
        cyc     = 0;
        mir_n   = 0;
        mir_err = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (bus.s_axis_tvalid[0] && bus.s_axis_tready[0] && src0_q.size() > 0) void'(src0_q.pop_front());
            if (bus.s_axis_tvalid[1] && bus.s_axis_tready[1] && src1_q.size() > 0) void'(src1_q.pop_front());
            if (bus.m_axis_tvalid && bus.m_axis_tready)
                out_q.push_back('{cyc, 8'(bus.m_axis_tid), bus.m_axis_tlast, bus.m_axis_tdata});
            if (bp_en && bus.m_axis_tvalid && bus.m_axis_tid == 1'b1) begin
                mir_n++;
                if (bus.s_axis_tready[1] !== bus.m_axis_tready || bus.s_axis_tready[0] !== 1'b0) mir_err++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst_n   = 1'b0;
        bp_en   = 1'b0;
        repeat (2) step();
        chk_quiet("reset");
        rst_n = 1'b1;
        step();

        // Normal ITCH add-order message from source 0, one arbitration cycle of latency.
        load_cyc = cyc;
        push_add(0, 64'h0102030405060708, 16'h0064, 32'h0000_2710);
        wait_out("t1", 15);
        chk_add("t1", 0, 64'h0102030405060708, 16'd100, 32'd10000);
        if (out_q.size() > 0) chk("t1_latency", 64'(out_q[0].cyc - load_cyc), 64'd2);
`ifdef ITCH_ARB_STATS_EN
        chk("t1_msg_cnt", 64'(stat_msg_cnt), 64'd1);
`endif

        // Fairness: both sources saturated, four messages each.
        reset_pulse();
        for (int m = 0; m < 4; m++) begin
            push_cnt_msg(0, 15, 8'(m * 16));
            push_cnt_msg(1, 15, 8'(64 + m * 16));
        end
        wait_out("t2", 120);
        for (int m = 0; m < 8; m++) begin
            chk_frame($sformatf("t2m%0d", m), m * 15, m % 2, 15, 8'((m % 2) * 64 + (m / 2) * 16));
            if (m > 0 && out_q.size() >= 120)
                chk($sformatf("t2_gap%0d", m), 64'(out_q[m*15].cyc - out_q[m*15-1].cyc), 64'd2);
        end
        step();
        out_q.delete();

        // Short message from source 1 then a normal one from source 0.
        push_cnt_msg(1, 10, 8'hA0);
        wait_out("t3", 15);
        chk_frame("t3", 0, 1, 10, 8'hA0);
`ifdef ITCH_ARB_STATS_EN
        chk("t3_short_cnt", 64'(stat_short_cnt), 64'd1);
`endif
        step();
        out_q.delete();
        push_add(0, 64'h1122334455667788, 16'h00C8, 32'h0000_4E20);
        wait_out("t3b", 15);
        chk_add("t3b", 0, 64'h1122334455667788, 16'd200, 32'd20000);
        step();
        out_q.delete();

        // Long message: 18 source bytes, 15 forwarded, 3 drained.
        push_cnt_msg(0, 18, 8'hC0);
        wait_out("t4", 15);
        repeat (10) step();
        chk_frame("t4", 0, 0, 18, 8'hC0);
        chk("t4_nbytes_after", 64'(out_q.size()), 64'd15);
        chk("t4_src_drained", 64'(src0_q.size()), 64'd0);
`ifdef ITCH_ARB_STATS_EN
        chk("t4_long_cnt", 64'(stat_long_cnt), 64'd1);
`endif
        out_q.delete();

        // Single-byte message: one data byte then fourteen pad bytes.
        push_cnt_msg(0, 1, 8'h5A);
        wait_out("t5", 15);
        chk_frame("t5", 0, 0, 1, 8'h5A);
        step();
        out_q.delete();

        // Backpressure: parser ready toggles every cycle.
        bp_en = 1'b1;
        push_cnt_msg(1, 15, 8'h30);
        wait_out("t6", 15);
        repeat (4) step();
        bp_en = 1'b0;
        chk_frame("t6", 0, 1, 15, 8'h30);
        chk("t6_nbytes_after", 64'(out_q.size()), 64'd15);
        chk("t6_mirror_err", 64'(mir_err), 64'd0);
        chk("t6_mirror_seen", 64'(mir_n > 4), 64'd1);
        out_q.delete();

        // Reset in the middle of a source-1 message.
        push_cnt_msg(1, 15, 8'h70);
        wait_out("t7pre", 8);
        #1;
        rst_n = 1'b0;
        #1;
        chk_quiet("t7_rst");
        src0_q.delete();
        src1_q.delete();
        step();
        out_q.delete();
        rst_n = 1'b1;
        step();
        push_cnt_msg(0, 15, 8'h10);
        wait_out("t7", 15);
        chk_frame("t7", 0, 0, 15, 8'h10);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/itch_msg_arbiter.md
# itch_msg_arbiter

Round-robin message scheduler that shares the single ITCH byte parser between `NUM_SRC` upstream byte feeds, for example the A/B line-handler streams. It grants one source per message and forwards that message's bytes to the parser's AXI-Stream input. It keeps the parser framed to exactly `MSG_BYTES` bytes per message: short messages are zero-padded and long messages are truncated, with the excess drained. It sits between the feed receivers and the parser.

## Interface
- `NUM_SRC`, 2: number of byte sources, legal range 2..8.
- `MSG_BYTES`, 15: fixed message length expected by the parser, including the type byte.
- `IDW`, `$clog2(NUM_SRC)` (minimum 1): source-id width.
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_axis_tdata`  in  NUM_SRC*8  source byte data, flattened; source k occupies bits [8k+7:8k].
- `s_axis_tvalid`  in  NUM_SRC  per-source byte valid.
- `s_axis_tlast`  in  NUM_SRC  per-source end-of-message flag.
- `s_axis_tready`  out  NUM_SRC  per-source ready; only the granted source, or none, is high.
- `m_axis_tdata`  out  8  byte to the parser.
- `m_axis_tvalid`  out  1  byte valid to the parser.
- `m_axis_tready`  in  1  parser ready.
- `m_axis_tlast`  out  1  high on byte index `MSG_BYTES-1`.
- `m_axis_tid`  out  IDW  granted source index; meaningful while `m_axis_tvalid` is high.
- `stat_msg_cnt`  out  32  completed output messages, saturating. Present only with `ITCH_ARB_STATS_EN`.
- `stat_short_cnt`  out  16  padded (short) messages, saturating. Present only with `ITCH_ARB_STATS_EN`.
- `stat_long_cnt`  out  16  truncated (long) messages, saturating. Present only with `ITCH_ARB_STATS_EN`.

## Operation
- **Registered state.** The block holds `state`, `grant` (IDW bits), `ptr` (IDW bits, round-robin start) and `cnt`. `cnt` is `$clog2(MSG_BYTES)` bits wide and counts bytes already emitted on the output.
- **IDLE**
  - All `s_axis_tready` are 0 and `m_axis_tvalid` is 0.
  - If any `s_axis_tvalid` bit is high, the winner is the first valid source at or after `ptr`, searching upward modulo `NUM_SRC`.
  - Next cycle: `grant` = winner, `cnt` = 0, go to FWD.
  - No byte is consumed in IDLE.
- **FWD**
  - Output mux: `m_axis_tdata` = source `grant` data; `m_axis_tvalid` = `s_axis_tvalid[grant]`; `s_axis_tready[grant]` = `m_axis_tready`; every other ready is 0.
  - `m_axis_tlast` = (`cnt == MSG_BYTES-1`).
  - On each handshake `cnt` increments, then one of these transitions applies:
    - `tlast` and `cnt == MSG_BYTES-1`: normal end. Go to IDLE and set `ptr` = `grant+1` modulo `NUM_SRC`.
    - `tlast` and `cnt < MSG_BYTES-1`: short message. Go to PAD and increment `short_cnt`.
    - No `tlast` and `cnt == MSG_BYTES-1`: long message. Go to DRAIN and increment `long_cnt`.
- **PAD**
  - `m_axis_tvalid` = 1 and `m_axis_tdata` = 0x00; all source readies are 0.
  - On each handshake `cnt` increments. The handshake at `cnt == MSG_BYTES-1` carries `m_axis_tlast`, then the block goes to IDLE and updates `ptr`.
- **DRAIN**
  - `m_axis_tvalid` = 0; `s_axis_tready[grant]` = 1. Source bytes are discarded.
  - The handshake that carries `s_axis_tlast` ends DRAIN: go to IDLE and update `ptr`.
- **Message count.** `stat_msg_cnt` increments on every output handshake that carries `m_axis_tlast`, padded messages included.
- **Counters.** All three counters saturate at their all-ones value and never wrap.
- **Grant hold.** A grant is held for the full message regardless of other requests. There is no preemption and no timeout.
- **Sources that deassert valid.** A granted source may drop `tvalid` mid-message; the block waits in FWD indefinitely.

## Timing
- **Reset values.** While `rst_n` is low, asynchronously: state = IDLE, `grant` = 0, `ptr` = 0, `cnt` = 0, counters = 0. This makes `m_axis_tvalid` = 0, `s_axis_tready` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0 and `m_axis_tid` = 0.
- **Reset mid-message.** The partial message is abandoned and no pad is emitted. After reset release the parser must be reset as well, or it is misaligned.
- **Latency.**
  - One arbitration cycle: a request seen in IDLE on cycle N gives the first byte on the output in cycle N+1.
  - Data path is combinational source-to-output; there is zero byte latency in FWD.
  - Minimum cost is one bubble cycle between consecutive messages.
  - Throughput is `MSG_BYTES` / (`MSG_BYTES`+1) bytes per cycle when all sources are saturated.
- **Output stability.** While `m_axis_tvalid=1` and `m_axis_tready=0`, `m_axis_tdata`, `m_axis_tlast` and `m_axis_tid` hold stable. The granted source obeys the same rule under AXI-Stream rules.
- **Single-byte message.** A message with `tlast` on byte 0 goes to PAD and emits `MSG_BYTES-1` zero bytes.
- **Simultaneous requests in IDLE.** Resolved purely by `ptr`.
- **Fairness.** With all sources requesting, grants rotate 0,1,…,`NUM_SRC-1`,0.

## Configuration
- `ITCH_ARB_STATS_EN` defined: the three `stat_*` ports and their saturating counters are built.
- Undefined: the ports and counters are absent. Framing, padding and drain behaviour is identical either way.

## Structure
- **Package `itch_pkg`:**
  - `ITCH_ADD_MSG_BYTES` = 15.
  - `ITCH_TYPE_ADD` = 8'h41.
  - Arbiter state encoding: IDLE=0, FWD=1, PAD=2, DRAIN=3.
- **Sub-module `rr_arbiter`:** combinational. Takes `req[NUM_SRC]` and `ptr`, and returns `gnt_idx` and `any_req`.

## Test plan
- **Normal message.** Source 0 sends 15 bytes: 0x41, order_id 0x0102030405060708, qty 0x0064, price 0x00002710, with `tlast` on byte 15 → the parser reports that order_id, quantity 100 and price 10000. `msg_cnt`=1.
- **Fairness.** Both sources request continuously, 4 messages each → `m_axis_tid` sequence is 0,1,0,1,0,1,0,1, with one bubble cycle between messages.
- **Short message.** Source 1 sends 10 bytes with `tlast` → 5 zero bytes follow, the last carrying `m_axis_tlast`. `short_cnt`=1. The next message from source 0 parses correctly.
- **Long message.** Source 0 sends 18 bytes → output ends at byte 15 with `tlast`. Bytes 16–18 are accepted from the source and not forwarded. `long_cnt`=1.
- **Backpressure.** `m_axis_tready` toggles every other cycle during a message → no byte is lost or duplicated, and the granted source sees ready mirror `m_axis_tready`.
- **Reset mid-message.** Assert `rst_n`=0 after byte 7 → all outputs are 0 immediately, before the next clock edge. After release, a fresh 15-byte message is forwarded starting at `tid` 0.
